// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin arbiter that shares the peripheral bus
// between two masters (M0 = CPU load/store unit, M1 = debug/DMA port).
// Each access runs as a fixed four-state sequence:
// IDLE -> ACCESS -> CAPTURE -> ACK.
// Peripheral q is captured one cycle after the bus strobe, and the result
// is returned to the granted master together with a one-cycle ack.
module periph_bus_arbiter #(
    parameter int NUM_PERIPH = 4,
    parameter int SEL_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [SEL_W+10:0]       m0_addr,
    input  logic [31:0]             m0_wdata,
    output logic [31:0]             m0_rdata,
    output logic                    m0_ack,
    output logic                    m0_err,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [SEL_W+10:0]       m1_addr,
    input  logic [31:0]             m1_wdata,
    output logic [31:0]             m1_rdata,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [10:0]             p_address,
    output logic [31:0]             p_data,
    output logic                    p_rden,
    output logic                    p_wren,
    output logic [NUM_PERIPH-1:0]   p_clken,
    input  logic [32*NUM_PERIPH-1:0] p_q
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    // Width-matched peripheral count, used for the out-of-range select check.
    localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PERIPH);

    state_t state, state_next;

    logic              start;
    logic              grant_next;
    logic              grant;        // 0 = M0, 1 = M1 for the access in flight
    logic              last_grant;
    logic              req_we;
    logic [SEL_W+10:0] req_addr;
    logic [31:0]       req_wdata;
    logic [SEL_W-1:0]  req_sel;
    logic              req_err;
    logic [NUM_PERIPH-1:0] req_onehot;
    logic              we_q;
    logic              err_q;
    logic [SEL_W-1:0]  sel_q;
    logic [31:0]       q_sel;
    logic [31:0]       rd_value;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An access starts only from IDLE, so requests seen
    // during the other three states are not acted on.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned (which would infer a latch).
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbitration and request decode. On a tie the master that was not
    // granted last time wins; otherwise the only requester is chosen.
    always_comb begin
        grant_next = (m0_req && m1_req) ? ~last_grant : m1_req;
        req_we     = grant_next ? m1_we    : m0_we;
        req_addr   = grant_next ? m1_addr  : m0_addr;
        req_wdata  = grant_next ? m1_wdata : m0_wdata;
        req_sel    = req_addr[SEL_W+10:11];
        req_err    = ({1'b0, req_sel} >= NP);
        req_onehot = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            req_onehot[i] = (req_sel == SEL_W'(i));
        end
    end

    // Pick the q bus of the latched select. Writes and bad selects return 0.
    always_comb begin
        q_sel = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                q_sel = p_q[32*i +: 32];
            end
        end
        rd_value = (we_q || err_q) ? 32'h0 : q_sel;
    end

    // Datapath and bus outputs. Each register is updated in the state where
    // that part of the access sequence happens.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // right-hand side below sees the value from before the clock edge.
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            p_address  <= '0;
            p_data     <= '0;
            p_rden     <= 1'b0;
            p_wren     <= 1'b0;
            p_clken    <= '0;
            m0_rdata   <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        grant      <= grant_next;
                        last_grant <= grant_next;
                        we_q       <= req_we;
                        err_q      <= req_err;
                        sel_q      <= req_sel;
                        p_address  <= req_addr[10:0];
                        p_data     <= req_wdata;
                        p_rden     <= ~req_we & ~req_err;
                        p_wren     <= req_we & ~req_err;
                        p_clken    <= req_err ? '0 : req_onehot;
                    end
                end
                ACCESS: begin
                    p_rden  <= 1'b0;
                    p_wren  <= 1'b0;
                    p_clken <= '0;
                end
                CAPTURE: begin
                    if (grant) begin
                        m1_rdata <= rd_value;
                        m1_ack   <= 1'b1;
                        m1_err   <= err_q;
                    end else begin
                        m0_rdata <= rd_value;
                        m0_ack   <= 1'b1;
                        m0_err   <= err_q;
                    end
                end
                ACK: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
